bit_reverse_stream: RTL and testbench

- Streaming reorder buffer for the NTT datapath.
- Accepts D coefficients of N bits, one per cycle, in natural order, and emits them in bit-reversed index order.
- This is the sequential, handshaked counterpart to the flat combinational bit-reverse permutation. It connects serial coefficient loaders and unloaders to the butterfly array.
- Single buffer, two phases: fill, then drain.

---
 rtl/bit_reverse_stream.sv | 113 +++++++++++
 tb/tb_bit_reverse_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_reverse_stream.sv
// Streaming bit-reverse reorder buffer: D coefficients arrive in natural order and leave in bit-reversed index order.
// Latency: first output is valid the cycle after the D-th input is accepted; an unstalled frame takes 2*D cycles.
// Backpressure: in_ready drops for the whole drain phase; out_ready low holds out_data/out_last stable.
// Optional frame checking (in_last input, sticky frame_err output) is built when BIT_REVERSE_STREAM_FRAME_CHECK_EN is defined.
module bit_reverse_stream #(
  parameter int N     = 17,
  parameter int D     = 8,
  parameter int LOG_D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
  ,
  input  logic         in_last,
  output logic         frame_err
`endif
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [LOG_D-1:0] LAST_IDX = LOG_D'(D - 1);

  state_t           state;
  logic [LOG_D-1:0] wr_cnt;
  logic [LOG_D-1:0] rd_cnt;
  logic [LOG_D-1:0] rd_rev;
  logic [N-1:0]     mem [D];

  logic in_fire;
  logic out_fire;

  // Handshake flags are pure decodes of the phase register, so no path runs from in_valid/out_ready.
  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && (rd_cnt == LAST_IDX);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Reverse the read index bits to pick the bit-reversed slot.
  always_comb begin
    rd_rev = '0;
    for (int i = 0; i < LOG_D; i++) begin
      rd_rev[i] = rd_cnt[LOG_D-1-i];
    end
  end

  // Output data is zero outside drain so idle cycles never expose stale buffer contents.
  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      out_data = mem[rd_rev];
    end
  end

  // Coefficient storage is write-only during fill and carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_cnt] <= in_data;
    end
  end

  // Phase sequencer: counters wrap only at frame boundaries, which also flips the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
              state  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (out_last) begin
              rd_cnt <= '0;
              state  <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
  // Sticky flag for in_last disagreeing with the beat position; data path is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (in_fire && (in_last != (wr_cnt == LAST_IDX))) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bit_reverse_stream.sv
// Bench for bit_reverse_stream: a reference model builds the expected bit-reversed frame on every D-th accept
// and a scoreboard queue is popped on each output transfer; handshake, latency and stall stability are checked alongside.
module tb_bit_reverse_stream;

  localparam int N     = 17;
  localparam int D     = 8;
  localparam int LOG_D = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         in_last;
`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
  logic         frame_err;
`endif

  bit_reverse_stream #(.N(N), .D(D), .LOG_D(LOG_D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
    ,
    .in_last   (in_last),
    .frame_err (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bitrev(input int i);
    int r = 0;
    for (int b = 0; b < LOG_D; b++) r |= ((i >> b) & 1) << (LOG_D - 1 - b);
    return r;
  endfunction

  // Scoreboard entries carry {last, data}.
  logic [N:0]   sb_q[$];
  logic [N-1:0] model_mem [D];
  int           beats     = 0;
  bit           draining  = 0;
  bit           pend_lat  = 0;
  int           lat_cyc   = 0;
  int           cyc       = 0;
  int           lo_run    = 0;
  bit           strict    = 1;
  bit           stall_hold = 0;
  logic [N-1:0] held_data;
  logic         held_last;
  int           n_out     = 0;
  bit           exp_err   = 0;
  int           rmode     = 0;

  // Monitor/model, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    logic [N:0] e;
    cyc++;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
      check("rst_frame_err", frame_err, 0);
`endif
      beats = 0; draining = 0; pend_lat = 0; stall_hold = 0; lo_run = 0; exp_err = 0;
      sb_q.delete();
    end else begin
`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
      check("frame_err", frame_err, exp_err);
`endif
      check("phase_excl", in_ready, !out_valid);
      if (!out_valid) check("idle_data", out_data, 0);
      if (stall_hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_data);
        check("stall_last", out_last, held_last);
      end
      stall_hold = 0;
      if (out_valid) begin
        if (pend_lat) begin
          check("first_out_latency", cyc, lat_cyc + 1);
          pend_lat = 0;
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e[N-1:0]);
            check("out_last", out_last, e[N]);
            n_out++;
            if (e[N]) draining = 0;
          end
        end else begin
          stall_hold = 1;
          held_data  = out_data;
          held_last  = out_last;
        end
      end
      if (!in_ready) begin
        lo_run++;
      end else begin
        if (lo_run != 0 && strict) check("drain_len", lo_run, D);
        lo_run = 0;
      end
      if (in_valid && in_ready) begin
        check("accept_while_draining", draining, 0);
        model_mem[beats] = in_data;
        if (in_last != (beats == D - 1)) exp_err = 1;
        beats++;
        if (beats == D) begin
          for (int k = 0; k < D; k++) sb_q.push_back({(k == D - 1), model_mem[bitrev(k)]});
          draining = 1;
          pend_lat = 1;
          lat_cyc  = cyc;
          beats    = 0;
        end
      end
    end
  end

  // out_ready pattern: always high, or 1,0,0 repeating.
  initial begin
    int rc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (rmode == 0) ? 1'b1 : ((rc % 3) == 0);
      rc++;
    end
  end

  task automatic send_beats(input int base, input int count, input int gap, input int last_idx);
    for (int i = 0; i < count; i++) begin
      bit acc;
      int t = 0;
      in_valid = 1'b1;
      in_data  = N'(base + i);
      in_last  = (i == last_idx);
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 300);
      if (!acc) check("in_accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb_q.size() != 0 || draining) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) check("drain_timeout", 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_out = 6 * D;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #2;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unstalled frame.
    strict = 1; rmode = 0;
    send_beats(0, D, 0, D - 1);
    wait_drain();

    // Output stalls 1,0,0.
    strict = 0; rmode = 1;
    send_beats(0, D, 0, D - 1);
    wait_drain();
    rmode = 0;
    repeat (2) begin @(posedge clk); #1; end
    strict = 1;

    // Sparse input, one beat every third cycle.
    send_beats(10, D, 2, D - 1);
    wait_drain();

    // Back-to-back frames.
    send_beats(0, D, 0, D - 1);
    send_beats(100, D, 0, D - 1);
    wait_drain();

    // Reset mid-fill, then a clean frame.
    send_beats(50, 5, 0, D - 1);
    do_reset();
    send_beats(20, D, 0, D - 1);
    wait_drain();

`ifdef BIT_REVERSE_STREAM_FRAME_CHECK_EN
    // in_last on the 4th beat; frame_err must stick until reset.
    send_beats(30, D, 0, 3);
    wait_drain();
    check("frame_err_sticky", frame_err, 1);
    exp_out += D;
    do_reset();
`endif

    check("queue_empty", sb_q.size(), 0);
    check("outputs_total", n_out, exp_out);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    check("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
